dec_cmd_parser: RTL
===================

DEC_CMD_PARSER -- requirements
Module: dec_cmd_parser

Interface
REQ-001: Parameter MAX_DIGITS, default 3, maximum number of decimal digits accepted per command.
REQ-002: Parameter VALUE_W, default 10, width of o_Value; SHALL hold 10^MAX_DIGITS-1.
REQ-003: Port i_Clk  input  1  single clock; all logic on rising edge.
REQ-004: Port i_Rst  input  1  synchronous, active-high reset.
REQ-005: Port i_Dec  input  4  decoded character: 0-9 digit, 10 SPACE, 11 ENTER, 12 FORWARD, 13 BACKWARD, 14 INVALID; 15 SHALL be treated as INVALID.
REQ-006: Port i_Valid  input  1  one-cycle strobe; i_Dec is sampled only when high.
REQ-007: Port o_Value  output  VALUE_W  magnitude of the last accepted command.
REQ-008: Port o_Dir  output  1  direction of the last accepted command; 0 forward, 1 backward.
REQ-009: Port o_Cmd_Valid  output  1  one-cycle pulse; o_Value/o_Dir are updated in the same cycle.
REQ-010: Port o_Err  output  1  one-cycle pulse marking a rejected command line.
REQ-011: Port o_Busy  output  1  high whenever the state is not IDLE.

Function
REQ-012: FSM states SHALL be IDLE, SIGN, DIGITS, TRAIL, ERROR; registered outputs only.
REQ-013: With i_Valid low, state, accumulator, digit count and outputs SHALL hold, except that pulses clear.
REQ-014: In IDLE: SPACE and ENTER ignored; FORWARD sets pending dir=0 ->SIGN; BACKWARD sets pending dir=1 ->SIGN; digit d sets dir=0, acc=d, cnt=1 ->DIGITS; INVALID ->ERROR.
REQ-015: In SIGN: SPACE ignored; digit d sets acc=d, cnt=1 ->DIGITS; ENTER pulses o_Err ->IDLE; FORWARD, BACKWARD or INVALID ->ERROR.
REQ-016: In DIGITS: digit with cnt<MAX_DIGITS sets acc=acc*10+d, cnt+1; digit with cnt==MAX_DIGITS ->ERROR (overflow); SPACE ->TRAIL; ENTER commits; FORWARD, BACKWARD or INVALID ->ERROR.
REQ-017: In TRAIL: SPACE ignored; ENTER commits; any other code ->ERROR.
REQ-018: Commit SHALL load o_Value=acc and o_Dir=pending dir, and pulse o_Cmd_Valid on the cycle after the ENTER strobe; then ->IDLE.
REQ-019: In ERROR: all codes except ENTER ignored; ENTER pulses o_Err on the cycle after the strobe ->IDLE.
REQ-020: acc*10+d arithmetic SHALL be computed wide enough not to truncate before the MAX_DIGITS check; values are unsigned.
REQ-021: o_Value and o_Dir SHALL change only on commit or reset; errors SHALL leave them unchanged.
REQ-022: o_Cmd_Valid and o_Err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per ENTER.
REQ-023: Leading zeros SHALL count toward MAX_DIGITS ("0012" overflows when MAX_DIGITS=3).
REQ-024: Back-to-back strobes on consecutive cycles SHALL be accepted without loss.

Reset
REQ-025: i_Rst high at a clock edge SHALL force IDLE, acc=0, cnt=0, pending dir=0, o_Value=0, o_Dir=0, o_Cmd_Valid=0, o_Err=0, o_Busy=0.
REQ-026: i_Rst SHALL take priority over i_Valid in the same cycle; a partially received command is discarded.

Verification
REQ-027: "+" "1" "2" "3" ENTER -> one cycle after ENTER: o_Cmd_Valid=1, o_Value=123, o_Dir=0.
REQ-028: "-" "7" ENTER -> o_Value=7, o_Dir=1, o_Cmd_Valid pulse; o_Busy=0 afterward.
REQ-029: "1" "2" "3" "4" ENTER after a prior commit of 123 -> o_Err pulse only; o_Value stays 123.
REQ-030: SPACE SPACE "4" "5" SPACE ENTER -> o_Value=45; then "4" SPACE "5" ENTER -> o_Err pulse.
REQ-031: "-" "9" then i_Rst for one cycle, then "3" ENTER -> o_Value=3, o_Dir=0.
REQ-032: ENTER alone -> no pulse; "+" ENTER -> o_Err pulse; INVALID "5" ENTER -> o_Err pulse, o_Value unchanged.

Source files
------------

// File: rtl/dec_cmd_parser_if.sv
// Character-in / command-out bus of the decimal command parser.
interface dec_cmd_parser_if #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10
);
  logic [3:0]         i_Dec;
  logic               i_Valid;
  logic [VALUE_W-1:0] o_Value;
  logic               o_Dir;
  logic               o_Cmd_Valid;
  logic               o_Err;
  logic               o_Busy;

  // Character source side
  modport master (
    output i_Dec, i_Valid,
    input  o_Value, o_Dir, o_Cmd_Valid, o_Err, o_Busy
  );

  // Parser side
  modport slave (
    input  i_Dec, i_Valid,
    output o_Value, o_Dir, o_Cmd_Valid, o_Err, o_Busy
  );
endinterface

// File: rtl/dec_cmd_parser.sv
// Parses a stream of decoded characters into signed-direction decimal commands:
// optional sign, 1..MAX_DIGITS digits, optional trailing spaces, ENTER.
module dec_cmd_parser #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned VALUE_W    = 10
) (
  input logic            i_Clk,
  input logic            i_Rst,
  dec_cmd_parser_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned ACC_W = VALUE_W + 4;

  localparam logic [3:0] C_SPACE = 4'd10;
  localparam logic [3:0] C_ENTER = 4'd11;
  localparam logic [3:0] C_FWD   = 4'd12;
  localparam logic [3:0] C_BACK  = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIGN,
    S_DIGITS,
    S_TRAIL,
    S_ERROR
  } state_e;

  state_e             state_q,     state_d;
  logic [VALUE_W-1:0] acc_q,       acc_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               dir_q,       dir_d;
  logic [VALUE_W-1:0] value_q,     value_d;
  logic               vdir_q,      vdir_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               err_q,       err_d;
  logic               busy_q,      busy_d;

  logic is_digit;
  assign is_digit = (bus.i_Dec <= 4'd9);

  // Next-state, accumulator and output-pulse logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    value_d     = value_q;
    vdir_d      = vdir_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;

    if (bus.i_Valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_digit) begin
            dir_d   = 1'b0;
            acc_d   = VALUE_W'(bus.i_Dec);
            cnt_d   = CNT_W'(1);
            state_d = S_DIGITS;
          end else if (bus.i_Dec == C_FWD) begin
            dir_d   = 1'b0;
            state_d = S_SIGN;
          end else if (bus.i_Dec == C_BACK) begin
            dir_d   = 1'b1;
            state_d = S_SIGN;
          end else if (bus.i_Dec != C_SPACE && bus.i_Dec != C_ENTER) begin
            state_d = S_ERROR;
          end
        end

        S_SIGN: begin
          if (is_digit) begin
            acc_d   = VALUE_W'(bus.i_Dec);
            cnt_d   = CNT_W'(1);
            state_d = S_DIGITS;
          end else if (bus.i_Dec == C_ENTER) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (bus.i_Dec != C_SPACE) begin
            state_d = S_ERROR;
          end
        end

        S_DIGITS: begin
          if (is_digit) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              // Widened product; the digit-count check keeps it within VALUE_W
              acc_d = VALUE_W'(ACC_W'(acc_q) * ACC_W'(4'd10) + ACC_W'(bus.i_Dec));
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              state_d = S_ERROR;
            end
          end else if (bus.i_Dec == C_SPACE) begin
            state_d = S_TRAIL;
          end else if (bus.i_Dec == C_ENTER) begin
            value_d     = acc_q;
            vdir_d      = dir_q;
            cmd_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            state_d = S_ERROR;
          end
        end

        S_TRAIL: begin
          if (bus.i_Dec == C_ENTER) begin
            value_d     = acc_q;
            vdir_d      = dir_q;
            cmd_valid_d = 1'b1;
            state_d     = S_IDLE;
          end else if (bus.i_Dec != C_SPACE) begin
            state_d = S_ERROR;
          end
        end

        S_ERROR: begin
          if (bus.i_Dec == C_ENTER) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      value_q     <= '0;
      vdir_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      value_q     <= value_d;
      vdir_q      <= vdir_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_Value     = value_q;
  assign bus.o_Dir       = vdir_q;
  assign bus.o_Cmd_Valid = cmd_valid_q;
  assign bus.o_Err       = err_q;
  assign bus.o_Busy      = busy_q;

endmodule
